// File: rtl/pawn_move_seq.sv
// Sequential pawn move evaluator: walks the forward, double, diagonal and
// en-passant squares through a 1-cycle-latency board read port.
module pawn_move_seq #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [CW-1:0] row,
  input  logic [CW-1:0] column,
  input  logic          color,
  input  logic          ep_valid,
  input  logic [CW-1:0] ep_col,
  output logic          rd_en,
  output logic [CW-1:0] rd_row,
  output logic [CW-1:0] rd_col,
  input  logic [4:0]    rd_data,
  output logic          busy,
  output logic          done,
  output logic [4:0]    allow,
  output logic          promote
);

  // state | meaning
  // IDLE  | waiting for start
  // RD_F1 | single step square read (issue / capture)
  // RD_F2 | double step square read
  // RD_DL | left diagonal capture read
  // RD_DR | right diagonal capture read
  // RD_EP | adjacent en-passant pawn read
  // FIN   | done pulse, result valid
  typedef enum logic [2:0] {IDLE, RD_F1, RD_F2, RD_DL, RD_DR, RD_EP, FIN} state_t;

  state_t        state, state_d;
  logic          phase, phase_d;
  logic [CW-1:0] r_row, r_col, r_epc;
  logic          r_color, r_epv;
  logic [4:0]    allow_d;
  logic          promote_d;
  logic          accept, advance;

  logic [CW-1:0] s_row, s_col, s_epc;
  logic          s_color, s_epv;
  logic [CW-1:0] fwd, fwd2, last_rank, start_row, ep_row;
  logic          ep_adj, c_f1, c_dl, c_dr, c_ep;
  logic [4:0]    ok, after, cand;

  // Conditions are evaluated from the live inputs at acceptance, latched copies afterwards.
  always_comb begin
    s_row   = r_row;
    s_col   = r_col;
    s_color = r_color;
    s_epv   = r_epv;
    s_epc   = r_epc;
    if (state == IDLE) begin
      s_row   = row;
      s_col   = column;
      s_color = color;
      s_epv   = ep_valid;
      s_epc   = ep_col;
    end
    fwd       = s_color ? s_row + CW'(1) : s_row - CW'(1);
    fwd2      = s_color ? s_row + CW'(2) : s_row - CW'(2);
    last_rank = s_color ? CW'(N - 1) : '0;
    start_row = s_color ? CW'(1) : CW'(N - 2);
    ep_row    = s_color ? CW'(N - 4) : CW'(3);
    ep_adj    = ({1'b0, s_epc} + (CW+1)'(1) == {1'b0, s_col}) ||
                ({1'b0, s_col} + (CW+1)'(1) == {1'b0, s_epc});
    c_f1      = (s_row != last_rank);
    c_dl      = c_f1 && (s_col != '0);
    c_dr      = c_f1 && (s_col != CW'(N - 1));
    c_ep      = s_epv && (s_row == ep_row) && ep_adj;
  end

  always_comb begin
    case (state)
      IDLE:    after = 5'b11111;
      RD_F1:   after = 5'b11110;
      RD_F2:   after = 5'b11100;
      RD_DL:   after = 5'b11000;
      RD_DR:   after = 5'b10000;
      default: after = 5'b00000;
    endcase
  end

  always_comb begin
    state_d   = state;
    phase_d   = phase;
    allow_d   = allow;
    promote_d = promote;
    accept    = 1'b0;
    advance   = 1'b0;
    rd_en     = 1'b0;
    rd_row    = '0;
    rd_col    = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          allow_d   = '0;
          promote_d = 1'b0;
          advance   = 1'b1;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        busy = 1'b1;
        if (!phase) begin
          rd_en   = 1'b1;
          phase_d = 1'b1;
          case (state)
            RD_F1:   begin rd_row = fwd;   rd_col = r_col;          end
            RD_F2:   begin rd_row = fwd2;  rd_col = r_col;          end
            RD_DL:   begin rd_row = fwd;   rd_col = r_col - CW'(1); end
            RD_DR:   begin rd_row = fwd;   rd_col = r_col + CW'(1); end
            default: begin rd_row = r_row; rd_col = r_epc;          end
          endcase
        end else begin
          phase_d = 1'b0;
          advance = 1'b1;
          case (state)
            RD_F1:   allow_d[3] = ~rd_data[0];
            RD_F2:   allow_d[4] = ~rd_data[0];
            RD_DL:   allow_d[2] = rd_data[0] & (rd_data[1] != r_color);
            RD_DR:   allow_d[1] = rd_data[0] & (rd_data[1] != r_color);
            default: allow_d[0] = rd_data[0] & (rd_data[1] != r_color) & (rd_data[4:2] == 3'b001);
          endcase
        end
      end
    endcase

    // F2 depends on the single-step result just captured, hence allow_d.
    ok   = {c_ep, c_dr, c_dl, (s_row == start_row) && allow_d[3], c_f1};
    cand = ok & after;
    if (advance) begin
      if (cand[0])      state_d = RD_F1;
      else if (cand[1]) state_d = RD_F2;
      else if (cand[2]) state_d = RD_DL;
      else if (cand[3]) state_d = RD_DR;
      else if (cand[4]) state_d = RD_EP;
      else begin
        state_d   = FIN;
        promote_d = (fwd == last_rank) && (|allow_d[3:1]);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      phase   <= 1'b0;
      r_row   <= '0;
      r_col   <= '0;
      r_color <= 1'b0;
      r_epv   <= 1'b0;
      r_epc   <= '0;
      allow   <= '0;
      promote <= 1'b0;
    end else begin
      state   <= state_d;
      phase   <= phase_d;
      allow   <= allow_d;
      promote <= promote_d;
      if (accept) begin
        r_row   <= row;
        r_col   <= column;
        r_color <= color;
        r_epv   <= ep_valid;
        r_epc   <= ep_col;
      end
    end
  end

endmodule

// File: tb/tb_pawn_move_seq.sv
// Self-checking bench for pawn_move_seq: directed scenarios plus random boards
// checked against a square-by-square reference model.
module tb_pawn_move_seq;
  localparam int N  = 8;
  localparam int CW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset_n, start, color, ep_valid;
  logic [CW-1:0] row, column, ep_col, rd_row, rd_col;
  logic          rd_en, busy, done, promote;
  logic [4:0]    rd_data, allow;

  logic [4:0] board [N][N];
  int n_tests = 0;
  int n_fail  = 0;

  int obs_reads[$];
  int exp_reads[$];
  bit seq_ok, busy_ok, hold_ok;
  int done_cyc;
  logic [4:0] obs_allow;
  logic obs_prom, post_busy;

  pawn_move_seq #(.N(N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .row(row), .column(column),
    .color(color), .ep_valid(ep_valid), .ep_col(ep_col), .rd_en(rd_en),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data), .busy(busy),
    .done(done), .allow(allow), .promote(promote)
  );

  always #5 clk = ~clk;

  // Board memory: data valid only in the cycle after the strobe, garbage otherwise.
  always @(posedge clk) rd_data <= rd_en ? board[rd_row][rd_col] : 5'($urandom);

  task automatic clear_board();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        board[i][j] = 5'b00000;
  endtask

  task automatic model(input int r, input int c, input bit clr, input bit ev, input int ec,
                       output logic [4:0] a, output logic p);
    int dir, last, st, epr, f;
    dir  = clr ? 1 : -1;
    last = clr ? N - 1 : 0;
    st   = clr ? 1 : N - 2;
    epr  = clr ? N - 4 : 3;
    f    = r + dir;
    a    = 5'b0;
    exp_reads.delete();
    if (r != last) begin
      exp_reads.push_back(f * 32 + c);
      a[3] = !board[f][c][0];
    end
    if (r == st && a[3]) begin
      exp_reads.push_back((f + dir) * 32 + c);
      a[4] = !board[f + dir][c][0];
    end
    if (r != last && c > 0) begin
      exp_reads.push_back(f * 32 + c - 1);
      a[2] = board[f][c-1][0] && (board[f][c-1][1] != clr);
    end
    if (r != last && c < N - 1) begin
      exp_reads.push_back(f * 32 + c + 1);
      a[1] = board[f][c+1][0] && (board[f][c+1][1] != clr);
    end
    if (ev && r == epr && (ec - c == 1 || c - ec == 1)) begin
      exp_reads.push_back(r * 32 + ec);
      a[0] = board[r][ec][0] && (board[r][ec][1] != clr) && (board[r][ec][4:2] == 3'b001);
    end
    p = (f == last) && (a[3] || a[2] || a[1]);
  endtask

  task automatic do_run(input int r, input int c, input bit clr, input bit ev, input int ec,
                        input bit retrig, input bit sad);
    int cyc;
    obs_reads.delete();
    seq_ok = 1; busy_ok = 1; hold_ok = 1; done_cyc = -1;
    obs_allow = 5'b0; obs_prom = 1'b0;
    @(negedge clk);
    row = CW'(r); column = CW'(c); color = clr; ep_valid = ev; ep_col = CW'(ec); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (cyc <= 40) begin
      if (rd_en) begin
        obs_reads.push_back(int'(rd_row) * 32 + int'(rd_col));
        if (cyc != 2 * obs_reads.size() - 1) seq_ok = 0;
      end
      if (done) begin
        done_cyc = cyc; obs_allow = allow; obs_prom = promote;
        if (busy) busy_ok = 0;
        break;
      end
      if (!busy) busy_ok = 0;
      row = CW'($urandom); column = CW'($urandom); color = 1'($urandom);
      ep_valid = 1'($urandom); ep_col = CW'($urandom);
      start = retrig && (cyc == 2);
      @(negedge clk);
      cyc++;
    end
    start = sad && (done_cyc > 0);
    @(negedge clk);
    start = 1'b0;
    post_busy = busy;
    if (done || allow !== obs_allow || promote !== obs_prom) hold_ok = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; row = '0; column = '0; color = 1'b0;
    ep_valid = 1'b0; ep_col = '0;
    clear_board();
    #2;
    n_tests++; if ({rd_en, busy, done} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl got %b want 000", {rd_en, busy, done}); end
    n_tests++; if (allow !== 5'b0) begin n_fail++; $display("FAIL reset_allow got %b want 00000", allow); end
    n_tests++; if (promote !== 1'b0) begin n_fail++; $display("FAIL reset_promote got %b want 0", promote); end
    n_tests++; if ({rd_row, rd_col} !== '0) begin n_fail++; $display("FAIL reset_addr got %0d,%0d want 0,0", rd_row, rd_col); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_directed();
    for (int i = 0; i < 10; i++) begin
      int r, c, ec, ed;
      bit clr, ev;
      logic [4:0] ea, ma;
      logic ep, mp;
      clear_board();
      ev = 0; ec = 0; ep = 0; clr = 0;
      case (i)
        0: begin r = 6; c = 4; ea = 5'b11000; ed = 9; end
        1: begin r = 6; c = 4; ea = 5'b00100; ed = 7;
                 board[5][3] = 5'b00011; board[5][5] = 5'b00001; board[5][4] = 5'b00001; end
        2: begin r = 1; c = 0; clr = 1; ea = 5'b11000; ed = 7; end
        3: begin r = 1; c = 7; clr = 1; ea = 5'b11000; ed = 7; end
        4: begin r = 3; c = 4; ev = 1; ec = 5; ea = 5'b01001; ed = 9; board[3][5] = 5'b00111; end
        5: begin r = 3; c = 4; ev = 1; ec = 5; ea = 5'b01000; ed = 9; board[3][5] = 5'b01011; end
        6: begin r = 3; c = 4; ev = 1; ec = 7; ea = 5'b01000; ed = 7; board[3][5] = 5'b00111; end
        7: begin r = 1; c = 2; ea = 5'b01010; ep = 1; ed = 7; board[0][3] = 5'b00011; end
        8: begin r = 0; c = 2; ea = 5'b00000; ed = 1; end
        default: begin r = 4; c = 2; clr = 1; ev = 1; ec = 1; ea = 5'b01001; ed = 9; board[4][1] = 5'b00101; end
      endcase
      model(r, c, clr, ev, ec, ma, mp);
      do_run(r, c, clr, ev, ec, 1'b0, 1'b0);
      n_tests++; if (obs_allow !== ea) begin n_fail++; $display("FAIL dir%0d_allow got %b want %b", i, obs_allow, ea); end
      n_tests++; if (obs_prom !== ep) begin n_fail++; $display("FAIL dir%0d_promote got %b want %b", i, obs_prom, ep); end
      n_tests++; if (done_cyc != ed) begin n_fail++; $display("FAIL dir%0d_done_cycle got %0d want %0d", i, done_cyc, ed); end
      n_tests++; if (obs_reads.size() != exp_reads.size()) begin n_fail++; $display("FAIL dir%0d_nreads got %0d want %0d", i, obs_reads.size(), exp_reads.size()); end
      else for (int k = 0; k < exp_reads.size(); k++) begin
        n_tests++; if (obs_reads[k] != exp_reads[k]) begin n_fail++; $display("FAIL dir%0d_read%0d got (%0d,%0d) want (%0d,%0d)", i, k, obs_reads[k]/32, obs_reads[k]%32, exp_reads[k]/32, exp_reads[k]%32); end
      end
      n_tests++; if (!seq_ok || !busy_ok || !hold_ok) begin n_fail++; $display("FAIL dir%0d_timing got seq/busy/hold %0d%0d%0d want 111", i, seq_ok, busy_ok, hold_ok); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int r, c, ec;
      bit clr, ev, rt, sd;
      logic [4:0] ma;
      logic mp;
      for (int a = 0; a < N; a++)
        for (int b = 0; b < N; b++)
          board[a][b] = ($urandom_range(0, 9) < 4) ?
                        {3'($urandom_range(1, 6)), 1'($urandom), 1'b1} : 5'b00000;
      r = $urandom_range(0, N - 1); c = $urandom_range(0, N - 1);
      clr = 1'($urandom); ev = 1'($urandom); ec = $urandom_range(0, N - 1);
      if ($urandom_range(0, 1) == 1) begin
        r = clr ? N - 4 : 3;
        ec = (c == 0) ? 1 : (c == N - 1) ? N - 2 : c + ($urandom_range(0, 1) ? 1 : -1);
        if ($urandom_range(0, 1) == 1) board[r][ec] = {3'b001, ~clr, 1'b1};
      end
      rt = ($urandom_range(0, 3) == 0);
      sd = ($urandom_range(0, 3) == 0);
      model(r, c, clr, ev, ec, ma, mp);
      do_run(r, c, clr, ev, ec, rt, sd);
      n_tests++; if (obs_allow !== ma) begin n_fail++; $display("FAIL rnd%0d_allow got %b want %b", i, obs_allow, ma); end
      n_tests++; if (obs_prom !== mp) begin n_fail++; $display("FAIL rnd%0d_promote got %b want %b", i, obs_prom, mp); end
      n_tests++; if (done_cyc != 2 * exp_reads.size() + 1) begin n_fail++; $display("FAIL rnd%0d_done_cycle got %0d want %0d", i, done_cyc, 2 * exp_reads.size() + 1); end
      n_tests++; if (obs_reads != exp_reads) begin n_fail++; $display("FAIL rnd%0d_reads got %0d reads want %0d reads (order/addr)", i, obs_reads.size(), exp_reads.size()); end
      n_tests++; if (!seq_ok || !busy_ok || !hold_ok || post_busy !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_timing got seq/busy/hold/post %0d%0d%0d%b want 1110", i, seq_ok, busy_ok, hold_ok, post_busy); end
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    clear_board();
    @(negedge clk);
    row = 3'd6; column = 3'd4; color = 1'b0; ep_valid = 1'b0; ep_col = '0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++; if ({busy, rd_en, allow} !== {2'b11, 5'b01000}) begin n_fail++; $display("FAIL rstmid_pre got busy/rd_en/allow %b%b/%b want 11/01000", busy, rd_en, allow); end
    reset_n = 1'b0;
    #1;
    n_tests++; if ({busy, rd_en, done, allow} !== 8'b0) begin n_fail++; $display("FAIL rstmid_async got busy/rd_en/done/allow %b%b%b/%b want 000/00000", busy, rd_en, done, allow); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    saw_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    n_tests++; if (saw_done) begin n_fail++; $display("FAIL rstmid_no_done got activity=1 want 0"); end
    do_run(6, 4, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    n_tests++; if (obs_allow !== 5'b11000 || done_cyc != 9) begin n_fail++; $display("FAIL rstmid_restart got allow %b done %0d want 11000 done 9", obs_allow, done_cyc); end
  endtask

  task automatic test_back_to_back();
    clear_board();
    board[5][3] = 5'b00011; board[5][5] = 5'b00001; board[5][4] = 5'b00001;
    do_run(6, 4, 1'b0, 1'b0, 0, 1'b1, 1'b1);
    n_tests++; if (obs_allow !== 5'b00100) begin n_fail++; $display("FAIL b2b_allow got %b want 00100", obs_allow); end
    n_tests++; if (done_cyc != 7) begin n_fail++; $display("FAIL b2b_done_cycle got %0d want 7", done_cyc); end
    n_tests++; if (post_busy !== 1'b0 || !hold_ok) begin n_fail++; $display("FAIL b2b_start_at_done got busy %b hold %0d want 0 1", post_busy, hold_ok); end
    do_run(1, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    n_tests++; if (obs_allow !== 5'b11000 && obs_allow !== 5'b01000) begin n_fail++; $display("FAIL b2b_next_run got %b want 01000", obs_allow); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
